ws2812_pixel_stream_encoder: RTL and testbench

//  Pixel-level WS2812 unipolar-RZ encoder. Accepts whole pixel words over valid/ready, shifts them out MSB-first

---
 rtl/ws2812_pixel_stream_encoder_pkg.sv | 28 ++
 rtl/ws2812_pixel_stream_encoder_if.sv | 25 ++
 rtl/ws2812_pixel_stream_encoder_bit_timer.sv | 47 ++++
 rtl/ws2812_pixel_stream_encoder.sv | 177 +++++++++++++++++
 tb/tb_ws2812_pixel_stream_encoder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pixel_stream_encoder_pkg.sv
// rtl/ws2812_pixel_stream_encoder_pkg.sv - WS2812 timing defaults, tick conversion and FSM state encoding
package ws2812_pixel_stream_encoder_pkg;

  localparam int DEF_CLK_FREQ_KHZ  = 10000;
  localparam int DEF_T_HI_TRUE_NS  = 700;
  localparam int DEF_T_HI_FALSE_NS = 300;
  localparam int DEF_T_PERIOD_NS   = 1100;
  localparam int DEF_T_RESET_NS    = 80000;
  localparam int DEF_PIXEL_BITS    = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TX    = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // ns / clock period in ns, truncated; computed as ns*kHz/1e6 to stay exact in integers
  function automatic int ns_to_ticks(input int ns, input int clk_khz);
    longint prod;
    prod = longint'(ns) * longint'(clk_khz);
    return int'(prod / 64'sd1000000);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_pixel_stream_encoder_if.sv
// rtl/ws2812_pixel_stream_encoder_if.sv - pixel word valid/ready stream into the encoder
interface ws2812_pixel_stream_encoder_if #(
  parameter int PIXEL_BITS = 24
);

  logic [PIXEL_BITS-1:0] pixel_data;
  logic                  pixel_valid;
  logic                  pixel_last;
  logic                  pixel_ready;

  modport master (
    output pixel_data,
    output pixel_valid,
    output pixel_last,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_valid,
    input  pixel_last,
    output pixel_ready
  );

endinterface

// File: rtl/ws2812_pixel_stream_encoder_bit_timer.sv
// rtl/ws2812_pixel_stream_encoder_bit_timer.sv - per-bit tick counter and registered RZ line driver
module ws2812_bit_timer #(
  parameter int CNT_W            = 10,
  parameter int T_HI_TRUE_TICKS  = 7,
  parameter int T_HI_FALSE_TICKS = 3,
  parameter int T_PERIOD_TICKS   = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,        // a bit is being shown this cycle
  input  logic keep,       // a bit will be shown next cycle
  input  logic next_bit,   // value of the bit shown next cycle
  output logic end_of_bit, // final tick of the current bit
  output logic line
);

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(T_PERIOD_TICKS - 1);
  localparam logic [CNT_W-1:0] HI_TRUE   = CNT_W'(T_HI_TRUE_TICKS);
  localparam logic [CNT_W-1:0] HI_FALSE  = CNT_W'(T_HI_FALSE_TICKS);

  logic [CNT_W-1:0] tick;
  logic [CNT_W-1:0] tick_next;
  logic [CNT_W-1:0] hi_ticks;

  assign end_of_bit = run && (tick == LAST_TICK);

  // Next tick restarts at 0 for a fresh bit (from idle or after a wrap); line is registered from it
  always_comb begin
    tick_next = '0;
    if (run && !end_of_bit) begin
      tick_next = tick + CNT_W'(1);
    end
    hi_ticks = next_bit ? HI_TRUE : HI_FALSE;
  end

  // Tick counter and data line; async reset drops the line mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
      line <= 1'b0;
    end else begin
      tick <= keep ? tick_next : '0;
      line <= keep && (tick_next < hi_ticks);
    end
  end

endmodule

// File: rtl/ws2812_pixel_stream_encoder.sv
// rtl/ws2812_pixel_stream_encoder.sv - WS2812 pixel stream encoder: handshake, shifter, FSM, latch timing
module ws2812_pixel_stream_encoder
  import ws2812_pixel_stream_encoder_pkg::*;
#(
  parameter int CLK_FREQ_KHZ  = DEF_CLK_FREQ_KHZ,
  parameter int T_HI_TRUE_NS  = DEF_T_HI_TRUE_NS,
  parameter int T_HI_FALSE_NS = DEF_T_HI_FALSE_NS,
  parameter int T_PERIOD_NS   = DEF_T_PERIOD_NS,
  parameter int T_RESET_NS    = DEF_T_RESET_NS,
  parameter int PIXEL_BITS    = DEF_PIXEL_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ws2812_pixel_stream_encoder_if.slave  pix,
  output logic                          busy,
  output logic                          underrun,
  output logic                          frame_done,
  output logic                          encoded_output
);

  localparam int T_HI_TRUE_TICKS  = ns_to_ticks(T_HI_TRUE_NS, CLK_FREQ_KHZ);
  localparam int T_HI_FALSE_TICKS = ns_to_ticks(T_HI_FALSE_NS, CLK_FREQ_KHZ);
  localparam int T_PERIOD_TICKS   = ns_to_ticks(T_PERIOD_NS, CLK_FREQ_KHZ);
  localparam int T_RESET_TICKS    = ns_to_ticks(T_RESET_NS, CLK_FREQ_KHZ);
  localparam int CNT_W            = $clog2(max_int(T_RESET_TICKS, T_PERIOD_TICKS) + 1);
  localparam int BIT_W            = $clog2(PIXEL_BITS);

  if (!(T_HI_FALSE_TICKS > 0 && T_HI_FALSE_TICKS < T_HI_TRUE_TICKS &&
        T_HI_TRUE_TICKS < T_PERIOD_TICKS && T_PERIOD_TICKS >= 3)) begin : g_bad_timing
    $error("ws2812: bit timing does not resolve to 0 < FALSE < TRUE < PERIOD, PERIOD >= 3 ticks");
  end
  if (PIXEL_BITS != 24 && PIXEL_BITS != 32) begin : g_bad_width
    $error("ws2812: PIXEL_BITS must be 24 or 32");
  end

  state_t                state;
  state_t                state_next;
  logic [PIXEL_BITS-1:0] shifter;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  last_q;
  logic [CNT_W-1:0]      latch_cnt;
  logic                  ready_en;
  logic                  ready;
  logic                  transfer;
  logic                  end_of_bit;
  logic                  last_bit;
  logic                  latch_done;
  logic                  keep;
  logic                  next_bit;
  logic                  underrun_next;
  logic                  frame_done_next;

  assign last_bit   = (bit_cnt == BIT_W'(PIXEL_BITS - 1));
  assign latch_done = (latch_cnt == CNT_W'(T_RESET_TICKS - 1));
  assign transfer   = pix.pixel_valid && ready;
  assign keep       = (state_next == ST_TX);
  assign busy       = (state != ST_IDLE);
  assign pix.pixel_ready = ready;

  // Bit shown next cycle: new word MSB on a load, following bit on a wrap, otherwise unchanged
  always_comb begin
    next_bit = shifter[PIXEL_BITS-1];
    if (transfer) begin
      next_bit = pix.pixel_data[PIXEL_BITS-1];
    end else if (end_of_bit) begin
      next_bit = shifter[PIXEL_BITS-2];
    end
  end

  // Next-state logic, ready and status pulse requests
  always_comb begin
    state_next      = state;
    ready           = 1'b0;
    underrun_next   = 1'b0;
    frame_done_next = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = ready_en;
        if (ready_en && pix.pixel_valid) begin
          state_next = ST_TX;
        end
      end
      ST_TX: begin
        if (end_of_bit && last_bit) begin
          ready = 1'b1;
          if (pix.pixel_valid) begin
            state_next = ST_TX;
          end else if (last_q) begin
            state_next = ST_LATCH;
          end else begin
            state_next    = ST_IDLE;
            underrun_next = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (latch_done) begin
          state_next      = ST_IDLE;
          frame_done_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Holds ready low during reset and releases it on the first clock afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Pixel shifter, bit counter and stored frame-end flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifter <= '0;
      bit_cnt <= '0;
      last_q  <= 1'b0;
    end else if (transfer) begin
      shifter <= pix.pixel_data;
      bit_cnt <= '0;
      last_q  <= pix.pixel_last;
    end else if (end_of_bit) begin
      shifter <= {shifter[PIXEL_BITS-2:0], 1'b0};
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Latch period counter, parked at 0 outside LATCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_cnt <= '0;
    end else if (state == ST_LATCH && !latch_done) begin
      latch_cnt <= latch_cnt + CNT_W'(1);
    end else begin
      latch_cnt <= '0;
    end
  end

  // Registered single-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      underrun   <= underrun_next;
      frame_done <= frame_done_next;
    end
  end

  ws2812_bit_timer #(
    .CNT_W            (CNT_W),
    .T_HI_TRUE_TICKS  (T_HI_TRUE_TICKS),
    .T_HI_FALSE_TICKS (T_HI_FALSE_TICKS),
    .T_PERIOD_TICKS   (T_PERIOD_TICKS)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (state == ST_TX),
    .keep       (keep),
    .next_bit   (next_bit),
    .end_of_bit (end_of_bit),
    .line       (encoded_output)
  );

endmodule

// File: tb/tb_ws2812_pixel_stream_encoder.sv
// tb/tb_ws2812_pixel_stream_encoder.sv - scoreboard bench for the WS2812 pixel stream encoder
module tb_ws2812_pixel_stream_encoder;

  localparam int T1 = 7;    // '1' high ticks at 10 MHz
  localparam int T0 = 3;    // '0' high ticks
  localparam int TP = 11;   // bit period ticks
  localparam int TR = 800;  // latch ticks

  logic clk;
  logic rst_n;
  logic busy0, underrun0, fd0, enc0;
  logic busy1, underrun1, fd1, enc1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] exp_q[$];

  ws2812_pixel_stream_encoder_if #(.PIXEL_BITS(24)) if0 ();
  ws2812_pixel_stream_encoder_if #(.PIXEL_BITS(32)) if1 ();

  ws2812_pixel_stream_encoder dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .pix            (if0),
    .busy           (busy0),
    .underrun       (underrun0),
    .frame_done     (fd0),
    .encoded_output (enc0)
  );

  ws2812_pixel_stream_encoder #(.PIXEL_BITS(32)) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .pix            (if1),
    .busy           (busy1),
    .underrun       (underrun1),
    .frame_done     (fd1),
    .encoded_output (enc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: decode high-pulse widths back into 24-bit words and compare with the scoreboard
  int          mon_hi   = 0;
  int          mon_nb   = 0;
  logic [23:0] mon_word = '0;
  logic        mon_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_hi   = 0;
      mon_nb   = 0;
      mon_word = '0;
      mon_prev = 1'b0;
    end else begin
      if (enc0) begin
        mon_hi++;
      end else if (mon_prev) begin
        n_tests++;
        if (mon_hi != T1 && mon_hi != T0) begin
          n_fail++;
          $display("FAIL pulse_width actual=%0d required=%0d or %0d", mon_hi, T0, T1);
        end
        mon_word = {mon_word[22:0], (mon_hi == T1)};
        mon_nb++;
        mon_hi = 0;
        if (mon_nb == 24) begin
          mon_nb = 0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pixel actual=%06h required=none", mon_word);
          end else begin
            check("pixel_word", mon_word, exp_q.pop_front());
          end
        end
      end
      mon_prev = enc0;
    end
  end

  // Offer one word; the expected word is queued once ready is seen before the accepting edge
  task automatic push_pixel(input logic [23:0] d, input bit l);
    bit done;
    done = 1'b0;
    @(negedge clk);
    if0.pixel_data  = d;
    if0.pixel_last  = l;
    if0.pixel_valid = 1'b1;
    for (int t = 0; t < 3000 && !done; t++) begin
      if (if0.pixel_ready) begin
        exp_q.push_back(d);
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      check("accept_timeout", 0, 1);
      if0.pixel_valid = 1'b0;
    end
  endtask

  task automatic wait_busy();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      if (busy0) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check("busy_timeout", 0, 1);
  endtask

  // Cycle-exact line model for one word: bit i high for T1/T0 ticks of a TP-tick period
  task automatic expect_wave(input logic [23:0] w, inout int errs);
    for (int i = 23; i >= 0; i--) begin
      for (int j = 0; j < TP; j++) begin
        if (enc0 !== (j < (w[i] ? T1 : T0))) errs++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_frame(input string name, input int n, input logic [23:0] w0,
                           input logic [23:0] w1, input logic [23:0] w2, input bit latch);
    logic [23:0] ws[3];
    int errs;
    ws   = '{w0, w1, w2};
    errs = 0;
    fork
      begin
        for (int i = 0; i < n; i++) push_pixel(ws[i], latch && (i == n - 1));
        @(negedge clk);
        if0.pixel_valid = 1'b0;
      end
      begin
        wait_busy();
        for (int i = 0; i < n; i++) expect_wave(ws[i], errs);
      end
    join
    check(name, errs, 0);
  endtask

  task automatic expect_latch();
    int bad;
    bad = 0;
    for (int k = 0; k < TR; k++) begin
      if (enc0 !== 1'b0 || busy0 !== 1'b1 || fd0 !== 1'b0) bad++;
      @(negedge clk);
    end
    check("latch_low_busy", bad, 0);
    check("frame_done_pulse", {fd0, busy0}, 2'b10);
    @(negedge clk);
    check("frame_done_clears", fd0, 0);
  endtask

  initial begin
    int errs, nready, first, idx, tk;
    bit seen;
    logic [31:0] w32;

    rst_n = 1'b0;
    if0.pixel_valid = 1'b0; if0.pixel_last = 1'b0; if0.pixel_data = '0;
    if1.pixel_valid = 1'b0; if1.pixel_last = 1'b0; if1.pixel_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs0", {enc0, if0.pixel_ready, busy0, underrun0, fd0}, 0);
    check("reset_outputs1", {enc1, if1.pixel_ready, busy1, underrun1, fd1}, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", if0.pixel_ready, 1);

    // 1: single pixel, latch, frame_done
    run_frame("t1_wave", 1, 24'hA50000, 24'h0, 24'h0, 1'b1);
    expect_latch();

    // 2: three contiguous pixels
    run_frame("t2_wave", 3, 24'h123456, 24'hFEDCBA, 24'h0F0F0F, 1'b1);
    expect_latch();

    // 3: starved after one non-last pixel
    run_frame("t3_wave", 1, 24'hC3A501, 24'h0, 24'h0, 1'b0);
    check("t3_underrun_state", {underrun0, busy0, if0.pixel_ready}, 3'b101);
    @(negedge clk);
    check("t3_underrun_clears", underrun0, 0);
    errs = 0;
    for (int k = 0; k < 900; k++) begin
      if (fd0 !== 1'b0) errs++;
      @(negedge clk);
    end
    check("t3_no_frame_done", errs, 0);

    // 4: reset at tick 4 of bit 5
    push_pixel(24'hFFFFFF, 1'b1);
    @(negedge clk);
    if0.pixel_valid = 1'b0;
    check("t4_busy", busy0, 1);
    repeat (5 * TP + 4) @(negedge clk);
    check("t4_line_high_before_reset", enc0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_reset_outputs", {enc0, if0.pixel_ready, busy0, underrun0, fd0}, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("t4_ready_low_at_release", if0.pixel_ready, 0);
    @(negedge clk);
    check("t4_idle_ready", {busy0, if0.pixel_ready}, 2'b01);
    run_frame("t4_post_reset_wave", 1, 24'h5A3C96, 24'h0, 24'h0, 1'b1);
    expect_latch();

    // 5: 32-bit strip, two back-to-back words
    w32 = 32'hFF0000FF;
    errs = 0; nready = 0; first = -1;
    @(negedge clk);
    if1.pixel_data  = w32;
    if1.pixel_last  = 1'b0;
    if1.pixel_valid = 1'b1;
    check("t5_ready_idle", if1.pixel_ready, 1);
    @(negedge clk);
    if1.pixel_last = 1'b1;
    for (int k = 0; k < 2 * 32 * TP; k++) begin
      idx = (k % (32 * TP)) / TP;
      tk  = k % TP;
      if (enc1 !== (tk < (w32[31 - idx] ? T1 : T0))) errs++;
      if (if1.pixel_ready) begin
        nready++;
        if (first < 0) first = k;
      end
      if (k == 32 * TP) if1.pixel_valid = 1'b0;
      @(negedge clk);
    end
    check("t5_wave", errs, 0);
    check("t5_ready_count", nready, 2);
    check("t5_first_ready_cycle", first, 32 * TP - 1);
    check("t5_latch_entered", {busy1, enc1}, 2'b10);
    repeat (TR + 10) @(negedge clk);
    check("t5_idle_after_latch", busy1, 0);

    // 6: random words, random gaps with junk data while valid is low
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 300)) : 0;
      if (gap > 0) begin
        @(negedge clk);
        if0.pixel_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          if0.pixel_data = 24'($urandom);
          if0.pixel_last = 1'($urandom);
          @(negedge clk);
        end
      end
      push_pixel(24'($urandom), ($urandom_range(0, 4) == 0));
    end
    @(negedge clk);
    if0.pixel_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      if (!busy0) seen = 1'b1;
      else @(negedge clk);
    end
    check("t6_drain_idle", seen, 1);
    repeat (2) @(negedge clk);
    check("t6_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
